// File: rtl/edge_threshold_map.sv
// Edge-map thresholding stage: converts each convolved RGB pixel to luma,
// compares it against a per-pixel threshold, blanks the frame border
// (kernel halo), and emits an all-ones / all-zeros word per pixel.
// It also counts edge pixels per frame and flags the frame's last pixel.
// Output path: one output register plus one skid entry, so x_ready is
// driven by a flop and never depends combinationally on y_ready.
module edge_threshold_map #(
    parameter int W      = 30,
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int BORDER = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] x_data,
    input  logic         x_valid,
    output logic         x_ready,
    output logic [W-1:0] y_data,
    output logic         y_valid,
    input  logic         y_ready,
    input  logic [7:0]   threshold,
    output logic         frame_done,
    output logic [16:0]  edge_count
);

    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [16:0]   run_count;

    logic          xfer;
    logic          col_last;
    logic          row_last;
    logic          last_pixel;
    logic [7:0]    r;
    logic [7:0]    g;
    logic [7:0]    b;
    logic [9:0]    luma_sum;
    logic [7:0]    luma;
    logic          in_border;
    logic          is_edge;
    logic [W-1:0]  result;

    logic          skid_full;
    logic [W-1:0]  skid_data;

    // The two low bits of each 10-bit colour channel do not contribute to luma.
    logic          pix_unused;
    assign pix_unused = ^{x_data[21:20], x_data[11:10], x_data[1:0]};

    assign x_ready    = !skid_full;
    assign xfer       = x_valid && x_ready;
    assign col_last   = (col == CW'(WIDTH - 1));
    assign row_last   = (row == RW'(HEIGHT - 1));
    assign last_pixel = col_last && row_last;

    // Luma, border test and edge decision for the pixel currently on x.
    always_comb begin
        r         = x_data[29:22];
        g         = x_data[19:12];
        b         = x_data[9:2];
        luma_sum  = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
        luma      = luma_sum[9:2];
        in_border = (col < CW'(BORDER)) || (col >= CW'(WIDTH - BORDER)) ||
                    (row < RW'(BORDER)) || (row >= RW'(HEIGHT - BORDER));
        is_edge   = (luma >= threshold) && !in_border;
        result    = is_edge ? {W{1'b1}} : {W{1'b0}};
    end

    // Pixel position, per-frame edge tally and the end-of-frame pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            col        <= '0;
            row        <= '0;
            run_count  <= '0;
            edge_count <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (xfer) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (last_pixel) begin
                    edge_count <= run_count + 17'(is_edge);
                    run_count  <= '0;
                    frame_done <= 1'b1;
                end else begin
                    run_count  <= run_count + 17'(is_edge);
                end
            end
        end
    end

    // Output register with skid entry; a transfer only reaches the skid when
    // the output register is occupied and stalled, so skid_full blocks input.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_valid   <= 1'b0;
            y_data    <= '0;
            skid_full <= 1'b0;
            skid_data <= '0;
        end else if (xfer) begin
            if (!y_valid || y_ready) begin
                y_valid <= 1'b1;
                y_data  <= result;
            end else begin
                skid_full <= 1'b1;
                skid_data <= result;
            end
        end else if (y_valid && y_ready) begin
            if (skid_full) begin
                y_data    <= skid_data;
                skid_full <= 1'b0;
            end else begin
                y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_edge_threshold_map.sv
// Bench for edge_threshold_map on a reduced 16x16 frame. A reference model
// derives each expected output from pixel index and luma arithmetic and
// tracks pipeline occupancy as a queue of pending results.
module tb_edge_threshold_map;

    localparam int W      = 30;
    localparam int WIDTH  = 16;
    localparam int HEIGHT = 16;
    localparam int BORDER = 2;
    localparam int NPIX   = WIDTH * HEIGHT;
    localparam int FULL_EDGES = (WIDTH - 2 * BORDER) * (HEIGHT - 2 * BORDER);

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] x_data;
    logic         x_valid;
    logic         x_ready;
    logic [W-1:0] y_data;
    logic         y_valid;
    logic         y_ready;
    logic [7:0]   threshold;
    logic         frame_done;
    logic [16:0]  edge_count;

    int checks = 0;
    int errors = 0;
    int single_thr = 120;

    edge_threshold_map #(
        .W(W), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BORDER(BORDER)
    ) dut (
        .clk(clk),
        .reset(reset),
        .x_data(x_data),
        .x_valid(x_valid),
        .x_ready(x_ready),
        .y_data(y_data),
        .y_valid(y_valid),
        .y_ready(y_ready),
        .threshold(threshold),
        .frame_done(frame_done),
        .edge_count(edge_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model state
    logic [W-1:0] exp_q[$];
    int           m_idx = 0;
    int           m_run = 0;
    int           m_ec  = 0;
    bit           m_fd  = 1'b0;
    bit           hold  = 1'b0;
    logic [W-1:0] hold_data;
    int           fd_count = 0;

    function automatic bit model_edge(input logic [W-1:0] d, input int thr, input int idx);
        int rr, gg, bb, luma, c, rw;
        rr   = int'(d[29:22]);
        gg   = int'(d[19:12]);
        bb   = int'(d[9:2]);
        luma = (rr + 2 * gg + bb) / 4;
        c    = idx % WIDTH;
        rw   = idx / WIDTH;
        return (luma >= thr) && (c >= BORDER) && (c < WIDTH - BORDER) &&
               (rw >= BORDER) && (rw < HEIGHT - BORDER);
    endfunction

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        bit e;
        logic [W-1:0] want;
        check("x_ready", x_ready, exp_q.size() < 2);
        check("y_valid", y_valid, exp_q.size() > 0);
        check("frame_done", frame_done, m_fd);
        check("edge_count", edge_count, m_ec);
        if (hold) begin
            check("y_valid_held", y_valid, 1);
            check("y_data_held", y_data, hold_data);
        end
        if (y_valid && y_ready) begin
            if (exp_q.size() == 0) begin
                check("y_unexpected", 1, 0);
            end else begin
                want = exp_q.pop_front();
                check("y_data", y_data, want);
            end
        end
        hold      = y_valid && !y_ready;
        hold_data = y_data;
        if (frame_done) fd_count++;
        m_fd = 1'b0;
        if (reset) begin
            exp_q.delete();
            m_idx = 0;
            m_run = 0;
            m_ec  = 0;
            hold  = 1'b0;
        end else if (x_valid && x_ready) begin
            e = model_edge(x_data, int'(threshold), m_idx);
            exp_q.push_back(e ? {W{1'b1}} : {W{1'b0}});
            m_run += int'(e);
            if (m_idx == NPIX - 1) begin
                m_ec  = m_run;
                m_run = 0;
                m_fd  = 1'b1;
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
    end

    // Pixel generator: 0 = flat 200 grey, 1 = single test pixel at (10,10),
    // other = random data and threshold.
    task automatic gen(input int pattern, input int k);
        case (pattern)
            0: begin
                x_data    = {8'd200, 2'($urandom), 8'd200, 2'($urandom), 8'd200, 2'($urandom)};
                threshold = 8'd128;
            end
            1: begin
                if (k == 10 * WIDTH + 10)
                    x_data = {8'd100, 2'b11, 8'd120, 2'b11, 8'd140, 2'b11};
                else
                    x_data = {8'd0, 2'b11, 8'd0, 2'b11, 8'd0, 2'b11};
                threshold = 8'(single_thr);
            end
            default: begin
                x_data    = 30'($urandom);
                threshold = 8'($urandom_range(0, 255));
            end
        endcase
    endtask

    // Drive n pixels; vmode 1 toggles x_valid, rmode 1 randomises y_ready.
    task automatic run_pixels(input int n, input int pattern, input int vmode,
                              input int rmode, input int k0);
        int sent = 0;
        int cyc  = 0;
        bit acc;
        gen(pattern, k0);
        while (sent < n && cyc < n * 8 + 50) begin
            x_valid = (vmode == 0) ? 1'b1 : (cyc % 2 == 0);
            y_ready = (rmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = x_valid && x_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                sent++;
                if (sent < n) gen(pattern, k0 + sent);
            end
        end
        x_valid = 1'b0;
        if (sent < n) check("run_timeout", sent, n);
    endtask

    task automatic drain();
        x_valid = 1'b0;
        y_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int acc;
        reset     = 1'b1;
        x_valid   = 1'b0;
        x_data    = '0;
        y_ready   = 1'b1;
        threshold = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_y_valid", y_valid, 0);
        check("rst_y_data", y_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_edge_count", edge_count, 0);
        check("rst_x_ready", x_ready, 1);

        // Steady flat frame
        run_pixels(NPIX, 0, 0, 0, 0);
        drain();
        check("flat_edge_count", edge_count, FULL_EDGES);
        check("flat_fd_count", fd_count, 1);

        // Same frame with x_valid toggling every cycle
        run_pixels(NPIX, 0, 1, 0, 0);
        drain();
        check("toggle_edge_count", edge_count, FULL_EDGES);
        check("toggle_fd_count", fd_count, 2);

        // Threshold boundary on the luma-120 pixel
        single_thr = 120;
        run_pixels(NPIX, 1, 0, 0, 0);
        drain();
        check("thr120_edge_count", edge_count, 1);
        single_thr = 121;
        run_pixels(NPIX, 1, 0, 0, 0);
        drain();
        check("thr121_edge_count", edge_count, 0);

        // Random data under random and toggling flow control
        run_pixels(NPIX, 2, 0, 1, 0);
        run_pixels(NPIX, 2, 1, 1, 0);
        drain();
        check("random_fd_count", fd_count, 6);

        // Stall from empty: two pixels fill output + skid, then input stalls
        acc = 0;
        y_ready = 1'b0;
        x_valid = 1'b1;
        gen(0, 0);
        repeat (5) begin
            @(negedge clk);
            if (x_valid && x_ready) acc++;
            @(posedge clk);
            #1;
            gen(0, acc);
        end
        check("stall_accepted", acc, 2);
        check("stall_x_ready", x_ready, 0);
        run_pixels(NPIX - 2, 0, 0, 0, 2);
        drain();
        check("stall_edge_count", edge_count, FULL_EDGES);
        check("stall_fd_count", fd_count, 7);

        // Reset mid-frame abandons the frame
        run_pixels(100, 0, 0, 0, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_y_valid", y_valid, 0);
        check("midrst_y_data", y_data, 0);
        check("midrst_edge_count", edge_count, 0);
        check("midrst_x_ready", x_ready, 1);
        check("midrst_fd_count", fd_count, 7);
        run_pixels(NPIX, 0, 0, 0, 0);
        drain();
        check("postrst_edge_count", edge_count, FULL_EDGES);
        check("postrst_fd_count", fd_count, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/edge_threshold_map.md
EDGE_THRESHOLD_MAP -- requirements
Module: edge_threshold_map

Interface
REQ-001 SHALL have parameter W, default 30: pixel word width, packed {R[9:0],G[9:0],B[9:0]}.
REQ-002 SHALL have parameter WIDTH, default 320: pixels per line.
REQ-003 SHALL have parameter HEIGHT, default 240: lines per frame.
REQ-004 SHALL have parameter BORDER, default 2: pixels blanked on each frame edge (5x5 kernel halo).
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port x, dstream.in (data W, valid 1, ready 1): convolved pixel stream from the edge convolution stage.
REQ-008 SHALL have port y, dstream.out (data W, valid 1, ready 1): binary edge-map pixel stream.
REQ-009 SHALL have port threshold, input, 8: luma threshold, sampled per pixel.
REQ-010 SHALL have port frame_done, output, 1: one-cycle pulse when the last pixel of a frame is accepted.
REQ-011 SHALL have port edge_count, output, 17: number of edge pixels in the last completed frame.

Function
REQ-012 SHALL treat an input transfer as x.valid & x.ready in the same cycle; all counting and processing occur only on transfers.
REQ-013 SHALL extract R=x.data[29:22], G=x.data[19:12], B=x.data[9:2] (8-bit unsigned each).
REQ-014 SHALL compute luma = (R + 2*G + B) >> 2, 10-bit unsigned intermediate, 8-bit result, no saturation needed (max 255).
REQ-015 SHALL mark a pixel as edge when luma >= threshold and the pixel is not in the border region.
REQ-016 SHALL define border region as col < BORDER, col >= WIDTH-BORDER, row < BORDER, or row >= HEIGHT-BORDER.
REQ-017 SHALL output y.data = all ones (30'h3FFFFFFF) for edge, all zeros otherwise.
REQ-018 SHALL keep col counter (0..WIDTH-1) and row counter (0..HEIGHT-1); col increments per transfer, wraps to 0 at WIDTH-1 and increments row; row wraps to 0 at HEIGHT-1.
REQ-019 SHALL pulse frame_done for exactly one cycle, the cycle after the transfer at col=WIDTH-1, row=HEIGHT-1.
REQ-020 SHALL accumulate a running edge counter per frame; on the last-pixel transfer, SHALL load edge_count with the running total including that pixel and clear the running counter to 0.
REQ-021 SHALL register output: result appears on y one cycle after the accepting transfer (latency 1).
REQ-022 SHALL contain a 1-entry output register plus 1-entry skid register; x.ready = !skid_full (registered, no combinational path from y.ready to x.ready).
REQ-023 SHALL, when y.valid & !y.ready and a transfer occurs, store the new result in the skid register; when y.ready returns, SHALL present output register then skid in order.
REQ-024 SHALL hold y.data and y.valid stable while y.valid & !y.ready.
REQ-025 SHALL never drop, duplicate, or reorder pixels; simultaneous input transfer and output transfer with empty skid SHALL pass through without using skid.

Reset
REQ-026 SHALL on reset set col=0, row=0, running count=0, edge_count=0, frame_done=0, y.valid=0, y.data=0, skid empty, x.ready=1 next cycle.
REQ-027 SHALL treat reset mid-frame as abandoning the frame: counters restart at pixel (0,0), no frame_done pulse, edge_count cleared.

Verification
REQ-028 Steady stream, y.ready=1, threshold=128, all pixels R=G=B=200 -> y.data=3FFFFFFF for cols 2..317 rows 2..237, 0 elsewhere; edge_count=316*236=74576; frame_done pulses once per 76800 transfers.
REQ-029 Pixel at (10,10) with R=100,G=120,B=140 (luma 120): threshold=120 -> ones; threshold=121 -> zeros.
REQ-030 y.ready held low 5 cycles during stream -> x.ready falls after 2 accepted pixels, y.data stable, all pixels emerge in order afterward with no loss.
REQ-031 Reset asserted at pixel 1000 of a frame -> outputs zero, next accepted pixel treated as (0,0), first frame_done after 76800 further transfers.
REQ-032 x.valid toggling 1/0 each cycle -> col/row advance only on transfers; edge_count identical to REQ-028 case.
